// File: rtl/region_color_detector_pkg.sv
// region_det_pkg: shared types, reset defaults and helpers for the region color detector.
package region_det_pkg;
  typedef enum logic [1:0] {CLS_RED, CLS_GREEN, CLS_BLUE, CLS_BLACK} color_class_e;
  localparam int THR_W = 16;
  localparam int STB_W = 4;
  typedef struct packed {
    logic [9:0]       x;
    logic [9:0]       y;
    color_class_e     color;
    logic [THR_W-1:0] thresh;
  } region_cfg_t;
  localparam logic [9:0] DEF_X0 = 10'd170;
  localparam logic [9:0] DEF_X1 = 10'd450;
  localparam logic [9:0] DEF_Y0 = 10'd125;
  localparam logic [9:0] DEF_Y1 = 10'd335;
  function automatic region_cfg_t default_cfg(input int idx);
    region_cfg_t c;
    c.x      = idx[0] ? DEF_X1 : DEF_X0;
    c.y      = idx[1] ? DEF_Y1 : DEF_Y0;
    c.color  = idx == 0 ? CLS_BLUE : idx == 1 ? CLS_RED : idx == 2 ? CLS_BLACK : CLS_GREEN;
    c.thresh = THR_W'(idx < 4);
    return c;
  endfunction
endpackage

// File: rtl/region_color_detector_classifier.sv
// pixel_color_classifier: combinational RGB444 class vector {black, blue, green, red}.
module pixel_color_classifier #(
  parameter int GRAY_TH = 2,
  parameter int BLACK_TH = 2
) (
  input  logic [3:0] r_i,
  input  logic [3:0] g_i,
  input  logic [3:0] b_i,
  output logic [3:0] cls_o
);
  logic [3:0] mx_rg, mn_rg, mx, mn;
  logic gray, black;
  always_comb begin
    mx_rg = r_i > g_i ? r_i : g_i;
    mn_rg = r_i < g_i ? r_i : g_i;
    mx    = mx_rg > b_i ? mx_rg : b_i;
    mn    = mn_rg < b_i ? mn_rg : b_i;
    gray  = (5'(mx) - 5'(mn)) < 5'(GRAY_TH);
    black = 5'(mx) <= 5'(BLACK_TH);
    cls_o = {black, !gray && mx == b_i, !gray && mx == g_i, !gray && mx == r_i};
  end
endmodule

// File: rtl/region_color_detector.sv
// region_color_detector: counts class-matching pixels per programmable region each frame,
// latching per-frame pass flags and a HOLD_FRAMES-debounced version.
module region_color_detector
  import region_det_pkg::*;
#(
  parameter int N_REG = 4,
  parameter int REG_SIZE = 20,
  parameter int CNT_W = 9,
  parameter int GRAY_TH = 2,
  parameter int BLACK_TH = 2,
  parameter int HOLD_FRAMES = 3,
  localparam int IDX_W = N_REG > 1 ? $clog2(N_REG) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vsync,
  input  logic             DE,
  input  logic [9:0]       x_pixel,
  input  logic [9:0]       y_pixel,
  input  logic [3:0]       r_in,
  input  logic [3:0]       g_in,
  input  logic [3:0]       b_in,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [9:0]       cfg_x,
  input  logic [9:0]       cfg_y,
  input  logic [1:0]       cfg_color,
  input  logic [CNT_W-1:0] cfg_thresh,
  output logic [N_REG-1:0] pass,
  output logic [N_REG-1:0] pass_stable,
  output logic             all_pass,
  output logic             frame_done
);
  logic [3:0] cls, cls_q;
  logic vs_q, frame_end, done_q, all_q;
  logic [N_REG-1:0] in_d, in_q, hit, en, pass_d, stable_d, pass_q, stable_q;
  logic [CNT_W-1:0] cnt_q [N_REG];
  logic [STB_W-1:0] stb_d [N_REG];
  logic [STB_W-1:0] stb_q [N_REG];
  region_cfg_t act_q [N_REG];
  region_cfg_t shd_q [N_REG];
  region_cfg_t shd_d [N_REG];

  pixel_color_classifier #(.GRAY_TH(GRAY_TH), .BLACK_TH(BLACK_TH)) u_cls (
    .r_i(r_in), .g_i(g_in), .b_i(b_in), .cls_o(cls)
  );

  assign frame_end = !vs_q && vsync;

  always_comb begin
    shd_d = shd_q;
    if (cfg_we && 32'(cfg_idx) < 32'(N_REG))
      shd_d[cfg_idx] = '{x: cfg_x, y: cfg_y, color: color_class_e'(cfg_color), thresh: THR_W'(cfg_thresh)};
    for (int i = 0; i < N_REG; i++) begin
      en[i]       = act_q[i].thresh != '0;
      in_d[i]     = DE &&
                    {1'b0, x_pixel} >= {1'b0, act_q[i].x} && {1'b0, x_pixel} < {1'b0, act_q[i].x} + 11'(REG_SIZE) &&
                    {1'b0, y_pixel} >= {1'b0, act_q[i].y} && {1'b0, y_pixel} < {1'b0, act_q[i].y} + 11'(REG_SIZE);
      hit[i]      = in_q[i] && cls_q[act_q[i].color] && en[i];
      pass_d[i]   = en[i] && THR_W'(cnt_q[i]) >= act_q[i].thresh;
      stb_d[i]    = pass_d[i] ? (stb_q[i] == STB_W'(HOLD_FRAMES) ? stb_q[i] : stb_q[i] + 1'b1) : '0;
      stable_d[i] = stb_d[i] == STB_W'(HOLD_FRAMES);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_q     <= 1'b1;
      cls_q    <= '0;
      in_q     <= '0;
      pass_q   <= '0;
      stable_q <= '0;
      all_q    <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < N_REG; i++) begin
        act_q[i] <= default_cfg(i);
        shd_q[i] <= default_cfg(i);
        cnt_q[i] <= '0;
        stb_q[i] <= '0;
      end
    end else begin
      vs_q   <= vsync;
      cls_q  <= cls;
      in_q   <= in_d;
      shd_q  <= shd_d;
      done_q <= frame_end;
      if (frame_end) begin
        pass_q   <= pass_d;
        stable_q <= stable_d;
        all_q    <= |en && (stable_d & en) == en;
        act_q    <= shd_d;
        stb_q    <= stb_d;
        for (int i = 0; i < N_REG; i++) cnt_q[i] <= '0;
      end else begin
        for (int i = 0; i < N_REG; i++)
          if (hit[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  assign pass        = pass_q;
  assign pass_stable = stable_q;
  assign all_pass    = all_q;
  assign frame_done  = done_q;
endmodule

// File: tb/tb_region_color_detector.sv
// tb_region_color_detector: directed vector table plus hand-built multi-frame sequences.
module tb_region_color_detector;
  logic clk = 1'b0, reset = 1'b1, vsync = 1'b0, DE = 1'b0, cfg_we = 1'b0;
  logic [9:0] x_pixel = '0, y_pixel = '0, cfg_x = '0, cfg_y = '0;
  logic [3:0] r_in = '0, g_in = '0, b_in = '0;
  logic [1:0] cfg_idx = '0, cfg_color = '0;
  logic [8:0] cfg_thresh = '0;
  logic [3:0] pass, pass_stable;
  logic all_pass, frame_done;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  region_color_detector dut (
    .clk(clk), .reset(reset), .vsync(vsync), .DE(DE), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x),
    .cfg_y(cfg_y), .cfg_color(cfg_color), .cfg_thresh(cfg_thresh), .pass(pass),
    .pass_stable(pass_stable), .all_pass(all_pass), .frame_done(frame_done)
  );

  typedef struct {
    int x; int y;
    logic [3:0] r, g, b;
    logic de;
    logic [3:0] ep;
  } vec_t;
  vec_t tv [16];
  int sc [4];
  logic [3:0] es;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pixd(input int x, input int y, input logic [3:0] r, input logic [3:0] g, input logic [3:0] b, input logic de);
    @(negedge clk);
    DE = de; x_pixel = 10'(x); y_pixel = 10'(y); r_in = r; g_in = g; b_in = b;
  endtask

  task automatic pix(input int x, input int y, input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    pixd(x, y, r, g, b, 1'b1);
  endtask

  task automatic end_frame();
    @(negedge clk); DE = 1'b0; cfg_we = 1'b0;
    @(negedge clk); vsync = 1'b1;
    @(negedge clk); vsync = 1'b0;
  endtask

  task automatic wr(input int idx, input int x, input int y, input int c, input int th);
    @(negedge clk);
    DE = 1'b0; cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_x = 10'(x); cfg_y = 10'(y);
    cfg_color = 2'(c); cfg_thresh = 9'(th);
    @(negedge clk); cfg_we = 1'b0;
  endtask

  task automatic rst();
    @(negedge clk); reset = 1'b1; DE = 1'b0; vsync = 1'b0; cfg_we = 1'b0;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic all4();
    pix(170, 125, 0, 0, 15);
    pix(450, 125, 15, 0, 0);
    pix(170, 335, 1, 1, 1);
    pix(450, 335, 0, 12, 3);
  endtask

  task automatic chk_frame(input string nm, input logic [3:0] p, input logic [3:0] s, input logic a);
    end_frame();
    chk({nm, ".done"}, frame_done, 1);
    chk({nm, ".pass"}, pass, p);
    chk({nm, ".stable"}, pass_stable, s);
    chk({nm, ".all"}, all_pass, a);
  endtask

  initial begin
    tv[0]  = '{170, 125, 4'd0,  4'd0,  4'd15, 1'b1, 4'b0001};
    tv[1]  = '{189, 144, 4'd0,  4'd0,  4'd15, 1'b1, 4'b0001};
    tv[2]  = '{190, 125, 4'd0,  4'd0,  4'd15, 1'b1, 4'b0000};
    tv[3]  = '{170, 145, 4'd0,  4'd0,  4'd15, 1'b1, 4'b0000};
    tv[4]  = '{169, 125, 4'd0,  4'd0,  4'd15, 1'b1, 4'b0000};
    tv[5]  = '{450, 125, 4'd15, 4'd0,  4'd0,  1'b1, 4'b0010};
    tv[6]  = '{450, 125, 4'd15, 4'd14, 4'd0,  1'b1, 4'b0010};
    tv[7]  = '{450, 125, 4'd15, 4'd15, 4'd0,  1'b1, 4'b0010};
    tv[8]  = '{450, 125, 4'd5,  4'd4,  4'd5,  1'b1, 4'b0000};
    tv[9]  = '{450, 125, 4'd5,  4'd3,  4'd5,  1'b1, 4'b0010};
    tv[10] = '{170, 335, 4'd2,  4'd2,  4'd2,  1'b1, 4'b0100};
    tv[11] = '{170, 335, 4'd3,  4'd0,  4'd0,  1'b1, 4'b0000};
    tv[12] = '{170, 335, 4'd2,  4'd0,  4'd0,  1'b1, 4'b0100};
    tv[13] = '{450, 335, 4'd0,  4'd9,  4'd1,  1'b1, 4'b1000};
    tv[14] = '{450, 335, 4'd0,  4'd0,  4'd0,  1'b1, 4'b0000};
    tv[15] = '{170, 125, 4'd0,  4'd0,  4'd15, 1'b0, 4'b0000};

    rst();
    chk("rst.pass", pass, 0);
    chk("rst.stable", pass_stable, 0);
    chk("rst.all", all_pass, 0);
    chk("rst.done", frame_done, 0);

    // Single-pixel frames against the default regions; stable flags from a saturating model.
    for (int i = 0; i < 4; i++) sc[i] = 0;
    for (int t = 0; t < 16; t++) begin
      pixd(tv[t].x, tv[t].y, tv[t].r, tv[t].g, tv[t].b, tv[t].de);
      for (int i = 0; i < 4; i++) begin
        sc[i] = tv[t].ep[i] ? (sc[i] < 3 ? sc[i] + 1 : 3) : 0;
        es[i] = sc[i] == 3;
      end
      chk_frame($sformatf("vec%0d", t), tv[t].ep, es, &es);
      @(negedge clk);
      chk($sformatf("vec%0d.done_pulse", t), frame_done, 0);
    end

    rst();
    for (int f = 1; f <= 3; f++) begin
      for (int k = 0; k < 4; k++) pix(k[0] ? 450 : 170, k[1] ? 335 : 125, 0, 0, 15);
      chk_frame($sformatf("blue%0d", f), 4'b0001, f == 3 ? 4'b0001 : 4'b0000, 1'b0);
    end

    rst();
    wr(1, 450, 125, 0, 50);
    chk_frame("thr.act", 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 49; k++) pix(450 + k % 20, 125 + k / 20, 15, 0, 0);
    chk_frame("thr49", 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 50; k++) pix(450 + k % 20, 125 + k / 20, 15, 0, 0);
    chk_frame("thr50", 4'b0010, 4'b0000, 1'b0);
    wr(1, 450, 125, 0, 511);
    end_frame();
    for (int k = 0; k < 600; k++) pix(450 + k % 20, 125 + (k / 20) % 20, 15, 0, 0);
    chk_frame("sat", 4'b0000 | 4'b0010, 4'b0000, 1'b0);

    rst();
    wr(0, 0, 0, 0, 1);
    pix(0, 0, 15, 0, 0);
    chk_frame("shadow.old", 4'b0000, 4'b0000, 1'b0);
    pix(0, 0, 15, 0, 0);
    chk_frame("shadow.new", 4'b0001, 4'b0000, 1'b0);
    pix(170, 125, 0, 0, 15);
    chk_frame("shadow.oldreg", 4'b0000, 4'b0000, 1'b0);

    rst();
    wr(0, 0, 0, 0, 0);
    wr(1, 0, 0, 0, 0);
    wr(2, 630, 470, 0, 100);
    wr(3, 1015, 0, 1, 1);
    end_frame();
    for (int y = 460; y < 480; y++) for (int x = 620; x < 640; x++) pix(x, y, 15, 0, 0);
    for (int y = 0; y < 10; y++) for (int x = 0; x < 10; x++) pix(x, y, 15, 0, 0);
    chk_frame("edge100", 4'b0100, 4'b0000, 1'b0);
    wr(2, 630, 470, 0, 101);
    end_frame();
    for (int y = 460; y < 480; y++) for (int x = 620; x < 640; x++) pix(x, y, 15, 0, 0);
    for (int y = 0; y < 10; y++) for (int x = 0; x < 10; x++) pix(x, y, 15, 0, 0);
    chk_frame("edge101", 4'b0000, 4'b0000, 1'b0);
    pix(5, 5, 0, 15, 0);
    chk_frame("nowrap", 4'b0000, 4'b0000, 1'b0);
    pix(1020, 5, 0, 15, 0);
    chk_frame("hi_x", 4'b1000, 4'b0000, 1'b0);

    rst();
    for (int f = 1; f <= 3; f++) begin
      all4();
      chk_frame($sformatf("hold%0d", f), 4'b1111, f == 3 ? 4'b1111 : 4'b0000, f == 3);
    end
    chk_frame("hold.fail", 4'b0000, 4'b0000, 1'b0);
    for (int f = 1; f <= 3; f++) begin
      all4();
      chk_frame($sformatf("rehold%0d", f), 4'b1111, f == 3 ? 4'b1111 : 4'b0000, f == 3);
    end
    for (int i = 1; i < 4; i++) wr(i, 0, 0, 0, 0);
    all4();
    chk_frame("dis.old", 4'b1111, 4'b1111, 1'b1);
    all4();
    chk_frame("dis.new", 4'b0001, 4'b0001, 1'b1);
    chk_frame("dis.empty", 4'b0000, 4'b0000, 1'b0);

    rst();
    pix(170, 125, 0, 0, 15);
    chk_frame("mid.pre", 4'b0001, 4'b0000, 1'b0);
    wr(1, 0, 0, 0, 0);
    for (int k = 0; k < 40; k++) pix(170 + k % 20, 125 + k / 20, 0, 0, 15);
    @(negedge clk); DE = 1'b0; vsync = 1'b1; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("mid.pass", pass, 0);
    chk("mid.stable", pass_stable, 0);
    chk("mid.all", all_pass, 0);
    chk("mid.done", frame_done, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 2) vsync = 1'b0;
      chk($sformatf("mid.nodone%0d", c), frame_done, 0);
    end
    chk_frame("mid.cleared", 4'b0000, 4'b0000, 1'b0);
    pix(450, 125, 15, 0, 0);
    chk_frame("mid.defaults", 4'b0010, 4'b0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/region_color_detector.md
Name: region_color_detector

Overview:
- Parametrised successor of the fixed 4-region color pass detector.
- Checks N_REG programmable square regions of the live VGA stream against a per-region target color class.
- Requires a programmable minimum count of matching pixels per frame, rather than a single pixel.
- Latches a per-frame result and a debounced result that must hold for HOLD_FRAMES consecutive frames. Sits beside the camera pipeline and feeds the game/motion FSM.

Parameters:
- N_REG, 4: number of regions (1..16).
- REG_SIZE, 20: region side length in pixels.
- CNT_W, 9: width of the per-region hit counter and threshold.
- GRAY_TH, 2: a pixel is gray when max-min < GRAY_TH.
- BLACK_TH, 2: a pixel is black when max <= BLACK_TH.
- HOLD_FRAMES, 3: consecutive passing frames required for pass_stable (1..15).

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- vsync  in  1  VGA vsync; its rising edge marks the frame boundary
- DE  in  1  active video
- x_pixel  in  10  current column
- y_pixel  in  10  current row
- r_in  in  4  red component
- g_in  in  4  green component
- b_in  in  4  blue component
- cfg_we  in  1  config write strobe
- cfg_idx  in  IDX_W=max(1,$clog2(N_REG))  region being written
- cfg_x  in  10  region left edge
- cfg_y  in  10  region top edge
- cfg_color  in  2  target class: 0 red, 1 green, 2 blue, 3 black
- cfg_thresh  in  CNT_W  minimum hits per frame; 0 disables the region
- pass  out  N_REG  per-region result of the last completed frame
- pass_stable  out  N_REG  debounced result
- all_pass  out  1  AND of pass_stable over enabled regions; 0 if no region is enabled
- frame_done  out  1  one-cycle pulse when results update

Behaviour:
- Reset, synchronous active-high, overrides everything:
  - All outputs are 0.
  - Hit and stable counters are 0.
  - Active and shadow configs load the defaults:
    - idx0: (170,125) blue
    - idx1: (450,125) red
    - idx2: (170,335) black
    - idx3: (450,335) green
    - Threshold 1 for idx0..3.
    - idx>=4 are disabled (thresh 0).
- Classification:
  - max/min are taken over r,g,b; gray when max-min < GRAY_TH; black when max <= BLACK_TH.
  - red = !gray && max==r. green = !gray && max==g. blue = !gray && max==b.
  - On a max tie a pixel may belong to several classes.
  - black is independent of gray.
- Pipeline: classification, region compare and DE are registered once (stage S1). Counters update from S1 on the next edge.
- Region i hit: x in [cfg_x, cfg_x+REG_SIZE) and y in [cfg_y, cfg_y+REG_SIZE), compared at 11 bits so there is no wrap.
  - A region extending past 639/479 simply never matches beyond the screen edge.
- Hit counter i increments on an S1 hit with a class match and thresh != 0. It saturates at 2^CNT_W-1 and never wraps.
- Frame end is the cycle where vs_d==0 and vsync==1 (vs_d is registered vsync; reset sets vs_d to 1, so there is no spurious edge after reset). On the next edge:
  - pass[i] <= (thresh!=0) && (cnt[i] >= thresh).
  - Hit counters clear; the S1 pixel is discarded, so clear wins over a simultaneous hit.
  - Stable counter: increments if pass_new (saturating at HOLD_FRAMES), else clears to 0.
  - pass_stable[i] <= (stable counter next value == HOLD_FRAMES).
  - Shadow config copies to active config.
  - frame_done pulses 1 cycle later, aligned with the updated pass and pass_stable.
- Config writes (cfg_we) land in shadow only and take effect at the next frame end. This avoids mid-frame region changes.
  - cfg_idx >= N_REG: write ignored.
  - A write in the same cycle as frame end: the new value is taken into active.
- Disabling a region (thresh 0) forces its pass and pass_stable to 0 at the next frame end.
- all_pass is registered, updated with pass_stable.

Decomposition:
- Package region_det_pkg:
  - color_class_e enum {CLS_RED, CLS_GREEN, CLS_BLUE, CLS_BLACK}.
  - region_cfg_t struct {x, y, color, thresh}.
  - Default coordinate/color constants.
  - Function default_cfg(idx).
- Sub-module pixel_color_classifier: combinational max/min/diff producing a 4-bit class vector. It is reused by the filter path.

Test Plan:
- Reset, then 1 frame with an all-blue image. -> pass=0001 after frame_done; all_pass=0; pass_stable=0001 only after the third such frame.
- Program idx1 thresh=50; paint 49 red pixels in region 1 in frame A and 50 in frame B. -> pass[1]=0 after A, 1 after B.
- Write cfg for idx0 mid-frame to (0,0) red. -> the current frame still evaluates (170,125) blue; the next frame uses the new region.
- Region at (630,470), size 20, full red screen, thresh 100. -> only 10x10=100 hits, pass=1; thresh 101 -> pass=0, no wrap hits.
- Pass for 3 frames, then 1 failing frame. -> pass_stable 1 then 0; the counter restarts, needing 3 new passes.
- Assert reset for 1 cycle mid-frame after 40 hits. -> all outputs 0, counters 0, defaults restored, no frame_done until the next vsync rise.
